mem_burst_ctrl: RTL and testbench
=================================

# mem_burst_ctrl

Parametrised, clocked successor to the behavioural main-memory model. It is a byte-addressed memory with a valid/ready request port, a configurable access latency in clock cycles, 1–4 beat bursts, per-byte write enables and a deterministic pseudorandom power-up fill. It sits between the cache/CPU side and the memory array, and replaces the bidirectional command/data bus with separate, synthesizable request, write-data and read-data channels.

## Interface
- MEM_SIZE, 262144: memory size in bytes; power of two, at least DATA_W/8.
- ADDR_W, 18: byte-address width; 2^ADDR_W ≥ MEM_SIZE.
- DATA_W, 16: beat width; one of 8, 16 or 32.
- LATENCY, 99: wait cycles between request accept and first beat; 0 allowed.
- SEED, 225526: LFSR seed for the fill; 0 is replaced by 1.
- INIT_EN, 1: 1 means fill the memory after every reset release; 0 means skip the fill.

- CLK  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  start byte address; aligned down to DATA_W/8.
- req_len  in  2  beats minus 1.
- wdata_valid  in  1  write beat present.
- wdata_ready  out  1  block can accept a write beat.
- wdata  in  DATA_W  write beat data.
- wbe  in  DATA_W/8  per-byte write enable for the beat.
- rd_valid  out  1  read beat valid; no backpressure.
- rd_data  out  DATA_W  read beat data.
- rd_last  out  1  final read beat.
- wr_done  out  1  one-cycle pulse after the last write beat.
- busy  out  1  block is not in IDLE.

## Operation
- States: INIT, IDLE, WAIT, XFER, DONE.
- Reset asserted, asynchronously: state goes to INIT if INIT_EN=1, otherwise IDLE. All outputs go to 0. The LFSR loads SEED. The fill index goes to 0.
- INIT:
  - Each cycle, writes the low DATA_W bits of the LFSR to word index k.
  - The LFSR then advances: 32-bit Galois, polynomial x^32+x^22+x^2+x+1.
  - After word MEM_SIZE/(DATA_W/8)-1 is written, the state goes to IDLE.
  - busy=1 and req_ready=0 throughout INIT.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch write flag, aligned address and len.
  - Next state is WAIT with count=LATENCY, or XFER directly if LATENCY=0.
- WAIT: count decrements each cycle; when count reaches 0, next state is XFER.
- XFER, read:
  - One beat per cycle, for len+1 consecutive cycles.
  - rd_data = word at the current address; rd_last on the final beat.
  - After the final beat, next state is IDLE.
- XFER, write:
  - wdata_ready=1.
  - Each wdata_valid&&wdata_ready cycle writes the bytes where wbe is 1; bytes where wbe is 0 are unchanged.
  - wdata_valid low stalls the burst with no timeout.
  - After the final beat, next state is DONE.
- DONE: wr_done=1 for one cycle, then IDLE.
- Address advances by DATA_W/8 per beat and wraps modulo MEM_SIZE.
- Address bits above log2(MEM_SIZE) are ignored.
- Reset during WAIT or XFER aborts the access. Write beats already accepted stay committed unless INIT refills the memory.
- Memory contents are not cleared by reset when INIT_EN=0.

## Timing
- All state and outputs are registered on the rising edge of CLK; reset is the only asynchronous path.
- Reset values: req_ready=0, wdata_ready=0, rd_valid=0, rd_last=0, rd_data=0, wr_done=0, busy=0.
  - busy becomes 1 on the first edge after release if INIT_EN=1.
- After reset release with INIT_EN=0, req_ready=1 from the first rising edge.
- With INIT_EN=1, req_ready rises MEM_SIZE/(DATA_W/8) edges after the first post-release edge.
- Read latency: first rd_valid is high in the cycle following edge LATENCY+1, counting the accept edge as edge 0. Beats are back-to-back.
- Write: wdata_ready is high from the same cycle position. A beat presented at the first opportunity is accepted with zero stall.
- req_ready is 0 from the cycle after accept until the state returns to IDLE.
- A request arriving on the same edge the block returns to IDLE waits one cycle.
- Read-after-write to the same address returns the new data; the write commits before DONE.
- Not idle-cycle exact: a bench must not assume anything beyond the rules above.

## Test plan
All scenarios use DATA_W=16, MEM_SIZE=64, ADDR_W=6, LATENCY=3, INIT_EN=0 unless stated otherwise.
- **Reset:** hold Reset=0 for 3 cycles, then release. All outputs are 0 during reset; req_ready=1 after the first edge; busy=0.
- **Single write then read:** write addr 0x10, len 0, wdata 0xBEEF, wbe 11. wr_done pulses once. Read addr 0x11 (aligns to 0x10): rd_valid at accept+4 edges, rd_data 0xBEEF, rd_last=1.
- **Byte enable:** write 0x1234 with wbe 01 over 0xBEEF. A read returns 0xBE34.
- **Burst wrap:** write addr 0x3E, len 3, data 0x1111/0x2222/0x3333/0x4444. Read addr 0x3E, len 3: four consecutive beats, same data, rd_last only on the fourth. A single read at 0x00 returns 0x2222.
- **Write stall:** drop wdata_valid for 2 cycles after beat 1 of a 3-beat write. No beat is lost or duplicated, wr_done pulses exactly once, and read-back matches.
- **Reset mid-read and fill:** with INIT_EN=1 and SEED=1, assert Reset during the second read beat. rd_valid drops immediately. req_ready stays low for 32 cycles after release; word 0 then reads 0x0001.

Source files
------------

// File: rtl/mem_burst_ctrl.sv
// Byte-addressed burst memory with a valid/ready request port, programmable access
// latency, 1-4 beat bursts, per-byte write enables and an LFSR power-up fill.
module mem_burst_ctrl #(
    parameter int unsigned MEM_SIZE = 262144,
    parameter int unsigned ADDR_W   = 18,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned LATENCY  = 99,
    parameter int unsigned SEED     = 225526,
    parameter bit          INIT_EN  = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [1:0]          req_len,
    input  logic                wdata_valid,
    output logic                wdata_ready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wbe,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_last,
    output logic                wr_done,
    output logic                busy
);

    localparam int unsigned BYTES     = DATA_W / 8;
    localparam int unsigned WORDS     = MEM_SIZE / BYTES;
    localparam int unsigned OFF_W     = $clog2(BYTES);
    localparam int unsigned IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned CNT_W     = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam logic [31:0] LFSR_INIT = (SEED == 0) ? 32'd1 : 32'(SEED);
    // Galois taps for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
    localparam logic [31:0] TAPS      = 32'h8020_0003;

    typedef enum logic [2:0] {StInit, StIdle, StWait, StXfer, StDone} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [IDX_W-1:0]  addr_q, addr_d;
    logic [IDX_W-1:0]  fill_q, fill_d;
    logic [31:0]       lfsr_q, lfsr_d;
    logic [1:0]        len_q, len_d;
    logic [1:0]        beat_q, beat_d;
    logic              write_q, write_d;
    logic              req_ready_q, req_ready_d;
    logic              wdata_ready_q, wdata_ready_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              wr_done_q, wr_done_d;
    logic              busy_q, busy_d;
    logic              accept;
    logic              wbeat;
    logic              unused_addr;

    logic [DATA_W-1:0] mem [WORDS];

    assign accept      = req_valid && req_ready_q;
    assign wbeat       = wdata_valid && wdata_ready_q;
    // Byte-offset bits and bits above the memory size are deliberately dropped
    assign unused_addr = ^req_addr;

    assign req_ready   = req_ready_q;
    assign wdata_ready = wdata_ready_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign rd_last     = rd_last_q;
    assign wr_done     = wr_done_q;
    assign busy        = busy_q;

    // Next-state and registered-output decode
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        addr_d        = addr_q;
        fill_d        = fill_q;
        lfsr_d        = lfsr_q;
        len_d         = len_q;
        beat_d        = beat_q;
        write_d       = write_q;
        req_ready_d   = 1'b0;
        wdata_ready_d = 1'b0;
        rd_valid_d    = 1'b0;
        rd_last_d     = 1'b0;
        rd_data_d     = rd_data_q;
        wr_done_d     = 1'b0;

        unique case (state_q)
            StInit: begin
                lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'd0);
                fill_d = fill_q + IDX_W'(1);
                if (fill_q == IDX_W'(WORDS - 1)) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                req_ready_d = 1'b1;
                if (accept) begin
                    req_ready_d = 1'b0;
                    write_d     = req_write;
                    addr_d      = req_addr[OFF_W +: IDX_W];
                    len_d       = req_len;
                    beat_d      = 2'd0;
                    count_d     = CNT_W'(LATENCY);
                    state_d     = (LATENCY == 0) ? StXfer : StWait;
                end
            end
            StWait: begin
                count_d = count_q - CNT_W'(1);
                if (count_q <= CNT_W'(1)) begin
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (!write_q) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = mem[addr_q];
                    rd_last_d  = (beat_q == len_q);
                    addr_d     = addr_q + IDX_W'(1);
                    beat_d     = beat_q + 2'd1;
                    if (beat_q == len_q) begin
                        state_d = StIdle;
                    end
                end else begin
                    wdata_ready_d = 1'b1;
                    if (wbeat) begin
                        addr_d = addr_q + IDX_W'(1);
                        beat_d = beat_q + 2'd1;
                        if (beat_q == len_q) begin
                            wdata_ready_d = 1'b0;
                            wr_done_d     = 1'b1;
                            state_d       = StDone;
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    // Control state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= INIT_EN ? StInit : StIdle;
            count_q       <= '0;
            addr_q        <= '0;
            fill_q        <= '0;
            lfsr_q        <= LFSR_INIT;
            len_q         <= '0;
            beat_q        <= '0;
            write_q       <= 1'b0;
            req_ready_q   <= 1'b0;
            wdata_ready_q <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_last_q     <= 1'b0;
            rd_data_q     <= '0;
            wr_done_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            addr_q        <= addr_d;
            fill_q        <= fill_d;
            lfsr_q        <= lfsr_d;
            len_q         <= len_d;
            beat_q        <= beat_d;
            write_q       <= write_d;
            req_ready_q   <= req_ready_d;
            wdata_ready_q <= wdata_ready_d;
            rd_valid_q    <= rd_valid_d;
            rd_last_q     <= rd_last_d;
            rd_data_q     <= rd_data_d;
            wr_done_q     <= wr_done_d;
            busy_q        <= busy_d;
        end
    end

    // Array write port: fill words during INIT, byte-masked beats during a write burst
    always_ff @(posedge clk) begin
        if (state_q == StInit) begin
            mem[fill_q] <= lfsr_q[DATA_W-1:0];
        end else if (wbeat) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (wbe[b]) begin
                    mem[addr_q][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl: one instance without fill for the transfer
// scenarios, one with fill (SEED=1) for the reset-during-read scenario.
module tb_mem_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst1_n, rst2_n;
    logic        req_valid, req_write, wdata_valid;
    logic [5:0]  req_addr;
    logic [1:0]  req_len;
    logic [15:0] wdata;
    logic [1:0]  wbe;

    logic        o1_req_ready, o1_wdata_ready, o1_rd_valid, o1_rd_last, o1_wr_done, o1_busy;
    logic [15:0] o1_rd_data;
    logic        o2_req_ready, o2_wdata_ready, o2_rd_valid, o2_rd_last, o2_wr_done, o2_busy;
    logic [15:0] o2_rd_data;

    // Selects which instance the drivers observe
    logic        sel = 1'b0;
    logic        req_ready, wdata_ready, rd_valid, rd_last, wr_done, busy;
    logic [15:0] rd_data;

    int n_cmp  = 0;
    int n_fail = 0;

    // Capture from drivers
    logic [15:0] rd_cap [4];
    logic [3:0]  rd_last_pat;
    int          rd_n, rd_first, rd_gap;
    logic [15:0] wr_data [4];
    logic [1:0]  wr_be [4];
    int          wr_first, wr_done_cnt;

    always #5 clk = ~clk;

    assign req_ready   = sel ? o2_req_ready   : o1_req_ready;
    assign wdata_ready = sel ? o2_wdata_ready : o1_wdata_ready;
    assign rd_valid    = sel ? o2_rd_valid    : o1_rd_valid;
    assign rd_last     = sel ? o2_rd_last     : o1_rd_last;
    assign rd_data     = sel ? o2_rd_data     : o1_rd_data;
    assign wr_done     = sel ? o2_wr_done     : o1_wr_done;
    assign busy        = sel ? o2_busy        : o1_busy;

    mem_burst_ctrl #(
        .MEM_SIZE(64), .ADDR_W(6), .DATA_W(16), .LATENCY(3), .SEED(225526), .INIT_EN(1'b0)
    ) dut1 (
        .clk(clk), .rst_n(rst1_n),
        .req_valid(req_valid), .req_ready(o1_req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wdata_valid(wdata_valid), .wdata_ready(o1_wdata_ready), .wdata(wdata), .wbe(wbe),
        .rd_valid(o1_rd_valid), .rd_data(o1_rd_data), .rd_last(o1_rd_last),
        .wr_done(o1_wr_done), .busy(o1_busy)
    );

    mem_burst_ctrl #(
        .MEM_SIZE(64), .ADDR_W(6), .DATA_W(16), .LATENCY(3), .SEED(1), .INIT_EN(1'b1)
    ) dut2 (
        .clk(clk), .rst_n(rst2_n),
        .req_valid(req_valid), .req_ready(o2_req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wdata_valid(wdata_valid), .wdata_ready(o2_wdata_ready), .wdata(wdata), .wbe(wbe),
        .rd_valid(o2_rd_valid), .rd_data(o2_rd_data), .rd_last(o2_rd_last),
        .wr_done(o2_wr_done), .busy(o2_busy)
    );

    // Bounded wait for req_ready, sampling 1 time unit after each edge
    task automatic wait_req_ready();
        int t = 0;
        while (!req_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
    endtask

    // Issue a read and capture beats with their edge number relative to the accept edge
    task automatic do_read(input logic [5:0] a, input logic [1:0] l);
        int prev = 0;
        rd_n = 0; rd_first = -1; rd_gap = 0; rd_last_pat = 4'b0;
        wait_req_ready();
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_len = l;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (rd_valid) begin
                if (rd_n == 0) rd_first = k;
                else if (k != prev + 1) rd_gap = 1;
                if (rd_n < 4) begin
                    rd_cap[rd_n]      = rd_data;
                    rd_last_pat[rd_n] = rd_last;
                end
                rd_n++;
                prev = k;
                if (rd_last) break;
            end
        end
    endtask

    // Issue a write of l+1 beats from wr_data/wr_be; drop wdata_valid 2 cycles after stall_beat
    task automatic do_write(input logic [5:0] a, input logic [1:0] l, input int stall_beat);
        int k = 0;
        int t;
        wr_first = -1; wr_done_cnt = 0;
        wait_req_ready();
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_len = l;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int b = 0; b <= int'(l); b++) begin
            wdata_valid = 1'b1; wdata = wr_data[b]; wbe = wr_be[b];
            t = 0;
            while (!wdata_ready && t < 40) begin
                @(posedge clk); #1;
                k++; t++;
            end
            if (wr_first < 0 && wdata_ready) wr_first = k;
            @(posedge clk); #1;
            k++;
            wdata_valid = 1'b0;
            if (b == stall_beat) begin
                repeat (2) @(posedge clk);
                #1;
            end
        end
        for (int i = 0; i < 6; i++) begin
            if (wr_done) wr_done_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        rst1_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({req_ready, wdata_ready, rd_valid, rd_last, rd_data, wr_done, busy} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got %h want 0",
                     {req_ready, wdata_ready, rd_valid, rd_last, rd_data, wr_done, busy});
        end
        rst1_n = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_fail++; $display("FAIL ready_before_edge got %b want 0", req_ready);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL ready_after_edge got %b want 1", req_ready);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL busy_idle got %b want 0", busy);
        end
    endtask

    task automatic test_single();
        wr_data[0] = 16'hBEEF; wr_be[0] = 2'b11;
        do_write(6'h10, 2'd0, -1);
        n_cmp++;
        if (wr_first !== 4) begin
            n_fail++; $display("FAIL single_wready_edge got %0d want 4", wr_first);
        end
        n_cmp++;
        if (wr_done_cnt !== 1) begin
            n_fail++; $display("FAIL single_wr_done got %0d want 1", wr_done_cnt);
        end
        do_read(6'h11, 2'd0);
        n_cmp++;
        if (rd_first !== 4) begin
            n_fail++; $display("FAIL single_rd_latency got %0d want 4", rd_first);
        end
        n_cmp++;
        if (rd_n !== 1) begin
            n_fail++; $display("FAIL single_rd_beats got %0d want 1", rd_n);
        end
        n_cmp++;
        if (rd_cap[0] !== 16'hBEEF) begin
            n_fail++; $display("FAIL single_rd_data got %h want beef", rd_cap[0]);
        end
        n_cmp++;
        if (rd_last_pat !== 4'b0001) begin
            n_fail++; $display("FAIL single_rd_last got %b want 0001", rd_last_pat);
        end
    endtask

    task automatic test_byte_enable();
        wr_data[0] = 16'h1234; wr_be[0] = 2'b01;
        do_write(6'h10, 2'd0, -1);
        n_cmp++;
        if (wr_done_cnt !== 1) begin
            n_fail++; $display("FAIL be_wr_done got %0d want 1", wr_done_cnt);
        end
        do_read(6'h10, 2'd0);
        n_cmp++;
        if (rd_cap[0] !== 16'hBE34) begin
            n_fail++; $display("FAIL be_rd_data got %h want be34", rd_cap[0]);
        end
    endtask

    task automatic test_burst_wrap();
        logic [15:0] exp [4];
        exp[0] = 16'h1111; exp[1] = 16'h2222; exp[2] = 16'h3333; exp[3] = 16'h4444;
        for (int i = 0; i < 4; i++) begin
            wr_data[i] = exp[i]; wr_be[i] = 2'b11;
        end
        do_write(6'h3E, 2'd3, -1);
        n_cmp++;
        if (wr_done_cnt !== 1) begin
            n_fail++; $display("FAIL wrap_wr_done got %0d want 1", wr_done_cnt);
        end
        do_read(6'h3E, 2'd3);
        n_cmp++;
        if (rd_n !== 4 || rd_gap !== 0 || rd_first !== 4) begin
            n_fail++;
            $display("FAIL wrap_rd_beats got n=%0d gap=%0d first=%0d want n=4 gap=0 first=4",
                     rd_n, rd_gap, rd_first);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rd_cap[i] !== exp[i]) begin
                n_fail++; $display("FAIL wrap_rd_data[%0d] got %h want %h", i, rd_cap[i], exp[i]);
            end
        end
        n_cmp++;
        if (rd_last_pat !== 4'b1000) begin
            n_fail++; $display("FAIL wrap_rd_last got %b want 1000", rd_last_pat);
        end
        do_read(6'h00, 2'd0);
        n_cmp++;
        if (rd_cap[0] !== 16'h2222) begin
            n_fail++; $display("FAIL wrap_word0 got %h want 2222", rd_cap[0]);
        end
    endtask

    task automatic test_write_stall();
        logic [15:0] exp [3];
        exp[0] = 16'hAAAA; exp[1] = 16'hBBBB; exp[2] = 16'hCCCC;
        for (int i = 0; i < 3; i++) begin
            wr_data[i] = exp[i]; wr_be[i] = 2'b11;
        end
        do_write(6'h20, 2'd2, 0);
        n_cmp++;
        if (wr_done_cnt !== 1) begin
            n_fail++; $display("FAIL stall_wr_done got %0d want 1", wr_done_cnt);
        end
        do_read(6'h20, 2'd2);
        n_cmp++;
        if (rd_n !== 3) begin
            n_fail++; $display("FAIL stall_rd_beats got %0d want 3", rd_n);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (rd_cap[i] !== exp[i]) begin
                n_fail++; $display("FAIL stall_rd_data[%0d] got %h want %h", i, rd_cap[i], exp[i]);
            end
        end
    endtask

    // Release reset and return the edge number (first post-release edge = 1) where req_ready rose
    task automatic release_and_count(output int ready_edge, output logic busy_e1);
        ready_edge = -1; busy_e1 = 1'b0;
        rst2_n = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (k == 1) busy_e1 = busy;
            if (req_ready) begin
                ready_edge = k;
                break;
            end
        end
    endtask

    task automatic test_reset_mid_read_fill();
        int          re;
        logic        b1;
        logic [15:0] exp [4];
        int          seen;
        exp[0] = 16'h0001; exp[1] = 16'h0003; exp[2] = 16'h0002; exp[3] = 16'h0001;
        rst1_n = 1'b0;
        sel    = 1'b1;
        release_and_count(re, b1);
        n_cmp++;
        if (re !== 33) begin
            n_fail++; $display("FAIL fill_ready_edge got %0d want 33", re);
        end
        n_cmp++;
        if (b1 !== 1'b1) begin
            n_fail++; $display("FAIL fill_busy got %b want 1", b1);
        end
        do_read(6'h00, 2'd3);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rd_cap[i] !== exp[i]) begin
                n_fail++; $display("FAIL fill_word[%0d] got %h want %h", i, rd_cap[i], exp[i]);
            end
        end
        // Read burst interrupted by reset on its second beat
        wait_req_ready();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 6'h00; req_len = 2'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        seen = 0;
        for (int k = 1; k <= 40 && seen < 2; k++) begin
            @(posedge clk); #1;
            if (rd_valid) seen++;
        end
        n_cmp++;
        if (seen !== 2 || rd_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_read_beat2 got beats=%0d valid=%b want 2 1", seen, rd_valid);
        end
        rst2_n = 1'b0;
        #1;
        n_cmp++;
        if (rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_read_drop got %b want 0", rd_valid);
        end
        repeat (2) @(posedge clk);
        #1;
        release_and_count(re, b1);
        n_cmp++;
        if (re !== 33) begin
            n_fail++; $display("FAIL refill_ready_edge got %0d want 33", re);
        end
        do_read(6'h00, 2'd0);
        n_cmp++;
        if (rd_cap[0] !== 16'h0001) begin
            n_fail++; $display("FAIL refill_word0 got %h want 0001", rd_cap[0]);
        end
    endtask

    initial begin
        rst1_n = 1'b0; rst2_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        wdata_valid = 1'b0; wdata = '0; wbe = '0;
        test_reset();
        test_single();
        test_byte_enable();
        test_burst_wrap();
        test_write_stall();
        test_reset_mid_read_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
